regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised 2-read/1-write general-purpose register file for the pipelined CPU datapath. Adds several things the single-cycle register file lacks: clocked writes, asynchronous reset, an optional hardwired zero register, write-to-read bypass, and a per-register busy scoreboard. The decode stage uses the scoreboard to detect RAW hazards on outstanding multi-cycle results (loads, mul/div). The block sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
we  in  1  write enable (writeback)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr_a  in  ADDR_W  read port A address
raddr_b  in  ADDR_W  read port B address
rdata_a  out  DATA_W  read port A data (combinational)
rdata_b  out  DATA_W  read port B data (combinational)
rbusy_a  out  1  port A register has an outstanding reservation
rbusy_b  out  1  port B register has an outstanding reservation
rsv_en  in  1  reserve destination register (issue of a long-latency op)
rsv_addr  in  ADDR_W  register to reserve
flush  in  1  clear all busy bits (pipeline flush)
busy_cnt  out  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset (rst_n low, async): all registers = 0; all busy bits = 0; busy_cnt = 0. Reads during reset return 0 and busy = 0. Release is synchronous to the next clk edge.
- Write: on posedge clk with we=1, gpr[waddr] <= wdata and busy[waddr] <= 0, unless a reservation for the same address occurs in the same cycle. Writes to non-busy registers are legal.
- Reservation: on posedge with rsv_en=1, busy[rsv_addr] <= 1.
- Same-cycle write and reserve to the same address: reservation wins, so busy stays 1 (a new producer has been issued). Data is still written.
- flush=1: all busy bits <= 0. A reservation in the same cycle still sets its bit, so rsv wins over flush. Flush does not alter register contents.
- ZERO_REG=1: writes and reservations to address 0 are ignored; rdata for address 0 = 0 and rbusy = 0, regardless of bypass.
- Read, combinational:
  - Default: rdata_x = gpr[raddr_x], rbusy_x = busy[raddr_x].
  - BYPASS=1 and we=1 and waddr==raddr_x (and not the zero register): rdata_x = wdata and rbusy_x = 0.
  - A same-cycle reservation does not affect the current-cycle rbusy; it is visible from the next cycle.
- BYPASS=0: reads return the pre-edge array value; the written value is visible the cycle after the write.
- busy_cnt is the population count of the busy vector, updated in the same edge as the busy bits. It never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
- Reset asserted mid-operation overrides all pending write, reserve and flush inputs immediately.
- No X propagation: every array entry is reset, so no uninitialised reads.

Test Plan:
- Reset then read: assert rst_n=0, read addr 5 and 31 -> rdata=0, rbusy=0, busy_cnt=0.
- Write/read: we=1, waddr=7, wdata=0xDEADBEEF, raddr_a=7 same cycle -> rdata_a=0xDEADBEEF (BYPASS=1), and still 0xDEADBEEF next cycle after we=0. With BYPASS=0 -> old value 0 in the write cycle, 0xDEADBEEF the following cycle.
- Zero register: write 0x1234 to addr 0 and reserve addr 0 -> rdata_a(0)=0, rbusy_a=0, busy_cnt unchanged.
- Scoreboard: reserve 3 -> next cycle rbusy_b(3)=1, busy_cnt=1. Write 3 with 0x55 -> rbusy_b=0 in the write cycle via bypass; next cycle busy_cnt=0.
- Collisions:
  - Write and reserve reg 9 in the same cycle -> next cycle rdata=written value, rbusy=1.
  - flush with rsv_en to reg 4, while regs 2 and 6 are busy -> next cycle only busy[4]=1, busy_cnt=1.
- Async reset mid-operation: regs 1 to 10 written and 4 busy, pulse rst_n low between clock edges -> outputs go to 0 immediately, busy_cnt=0 without a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: writeback write port, two decode read ports with busy
// flags, reservation/flush controls and the registered busy count.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              rbusy_a;
    logic              rbusy_b;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              flush;
    logic [ADDR_W:0]   busy_cnt;

    // Pipeline side: drives requests, observes read data and scoreboard
    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr, flush,
        input  rdata_a, rdata_b, rbusy_a, rbusy_b, busy_cnt
    );

    // Register file side
    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr, flush,
        output rdata_a, rdata_b, rbusy_a, rbusy_b, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with write-to-read bypass, optional hardwired
// zero register and a per-register busy scoreboard for RAW hazard detection.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_scoreboard_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    // Per-register write/reserve decode. The zero register never matches, so
    // it keeps its reset value and never becomes busy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
            logic wr_hit;
            logic rsv_hit;

            assign wr_hit  = !HARD_ZERO && rf.we     && (rf.waddr    == ADDR_W'(gi));
            assign rsv_hit = !HARD_ZERO && rf.rsv_en && (rf.rsv_addr == ADDR_W'(gi));

            // A new reservation beats both flush and the completing write
            assign busy_d[gi] = rsv_hit | (busy_q[gi] & ~rf.flush & ~wr_hit);

            // Register storage; every entry resets so reads are never X
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gpr_q[gi] <= '0;
                end else if (wr_hit) begin
                    gpr_q[gi] <= rf.wdata;
                end
            end
        end
    endgenerate

    // Population count of the next busy vector so the count tracks the bits
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard state and its registered count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rf.busy_cnt = busy_cnt_q;

    // Combinational read ports: array value, then bypass, then zero register;
    // everything reads as zero while reset is held.
    always_comb begin
        rf.rdata_a = '0;
        rf.rbusy_a = 1'b0;
        rf.rdata_b = '0;
        rf.rbusy_b = 1'b0;
        if (rst_n) begin
            rf.rdata_a = gpr_q[rf.raddr_a];
            rf.rbusy_a = busy_q[rf.raddr_a];
            if ((BYPASS != 0) && rf.we && (rf.waddr == rf.raddr_a)) begin
                rf.rdata_a = rf.wdata;
                rf.rbusy_a = 1'b0;
            end
            if ((ZERO_REG != 0) && (rf.raddr_a == '0)) begin
                rf.rdata_a = '0;
                rf.rbusy_a = 1'b0;
            end

            rf.rdata_b = gpr_q[rf.raddr_b];
            rf.rbusy_b = busy_q[rf.raddr_b];
            if ((BYPASS != 0) && rf.we && (rf.waddr == rf.raddr_b)) begin
                rf.rdata_b = rf.wdata;
                rf.rbusy_b = 1'b0;
            end
            if ((ZERO_REG != 0) && (rf.raddr_b == '0)) begin
                rf.rdata_b = '0;
                rf.rbusy_b = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (bypass+zero-reg, and plain)
// share one stimulus stream and are checked against an array-based model,
// plus a directed vector table and an asynchronous reset sequence.
module tb_regfile_scoreboard;
    logic        clk;
    logic        rst_n;
    logic        we_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;
    logic [4:0]  raddr_a_s;
    logic [4:0]  raddr_b_s;
    logic        rsv_en_s;
    logic [4:0]  rsv_addr_s;
    logic        flush_s;

    int n_checks = 0;
    int n_errors = 0;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

    assign if0.we = we_s;           assign if1.we = we_s;
    assign if0.waddr = waddr_s;     assign if1.waddr = waddr_s;
    assign if0.wdata = wdata_s;     assign if1.wdata = wdata_s;
    assign if0.raddr_a = raddr_a_s; assign if1.raddr_a = raddr_a_s;
    assign if0.raddr_b = raddr_b_s; assign if1.raddr_b = raddr_b_s;
    assign if0.rsv_en = rsv_en_s;   assign if1.rsv_en = rsv_en_s;
    assign if0.rsv_addr = rsv_addr_s; assign if1.rsv_addr = rsv_addr_s;
    assign if0.flush = flush_s;     assign if1.flush = flush_s;

    // cfg0: BYPASS=1, ZERO_REG=1; cfg1: BYPASS=0, ZERO_REG=0
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rf(if0)
    );
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rf(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_gpr  [2][32];
    bit          m_busy [2][32];

    function automatic bit cfg_byp(int c);  return (c == 0); endfunction
    function automatic bit cfg_zero(int c); return (c == 0); endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin
                m_gpr[c][r]  = '0;
                m_busy[c][r] = 1'b0;
            end
    endtask

    // Apply one clock edge worth of the architectural rules
    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (flush_s)
                for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
            if (we_s && !(cfg_zero(c) && waddr_s == 0)) begin
                m_gpr[c][waddr_s]  = wdata_s;
                m_busy[c][waddr_s] = 1'b0;
            end
            if (rsv_en_s && !(cfg_zero(c) && rsv_addr_s == 0))
                m_busy[c][rsv_addr_s] = 1'b1;
        end
    endtask

    task automatic model_read(input int c, input logic [4:0] a,
                              output logic [31:0] d, output logic b);
        d = m_gpr[c][a];
        b = m_busy[c][a];
        if (!rst_n || (cfg_zero(c) && a == 0)) begin
            d = '0;
            b = 1'b0;
        end else if (cfg_byp(c) && we_s && waddr_s == a) begin
            d = wdata_s;
            b = 1'b0;
        end
    endtask

    function automatic int model_cnt(int c);
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[c][r]);
        return n;
    endfunction

    task automatic chk(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cfg%0d: got %h expected %h (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    task automatic get_out(input int c, output logic [31:0] da, output logic ba,
                           output logic [31:0] db, output logic bb, output logic [5:0] cnt);
        if (c == 0) begin
            da = if0.rdata_a; ba = if0.rbusy_a; db = if0.rdata_b; bb = if0.rbusy_b; cnt = if0.busy_cnt;
        end else begin
            da = if1.rdata_a; ba = if1.rbusy_a; db = if1.rdata_b; bb = if1.rbusy_b; cnt = if1.busy_cnt;
        end
    endtask

    task automatic model_check();
        logic [31:0] da, db, eda, edb;
        logic ba, bb, eba, ebb;
        logic [5:0] cnt;
        for (int c = 0; c < 2; c++) begin
            get_out(c, da, ba, db, bb, cnt);
            model_read(c, raddr_a_s, eda, eba);
            model_read(c, raddr_b_s, edb, ebb);
            chk("model rdata_a", c, da, eda);
            chk("model rbusy_a", c, 32'(ba), 32'(eba));
            chk("model rdata_b", c, db, edb);
            chk("model rbusy_b", c, 32'(bb), 32'(ebb));
            chk("model busy_cnt", c, 32'(cnt), 32'(model_cnt(c)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we_s = 0; waddr_s = 0; wdata_s = 0; rsv_en_s = 0; rsv_addr_s = 0; flush_s = 0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr_a;
        logic [4:0]  raddr_b;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic        flush;
        logic [31:0] e_rda;
        logic        e_rba;
        logic [31:0] e_rdb;
        logic        e_rbb;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] da, db;
        logic ba, bb;
        logic [5:0] cnt;

        // Expected values for cfg0 (bypass + zero register), one record per cycle
        vecs[0]  = '{1, 7, 32'hDEADBEEF, 7, 5, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,        7, 5, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0};
        vecs[2]  = '{1, 0, 32'h1234,     0, 7, 1, 0, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,        0, 3, 1, 3, 0, 32'h0, 0, 32'h0, 0, 0};
        vecs[4]  = '{1, 3, 32'h55,       0, 3, 0, 0, 0, 32'h0, 0, 32'h55, 0, 1};
        vecs[5]  = '{0, 0, 32'h0,        0, 3, 0, 0, 0, 32'h0, 0, 32'h55, 0, 0};
        vecs[6]  = '{1, 9, 32'hA5A5A5A5, 9, 3, 1, 9, 0, 32'hA5A5A5A5, 0, 32'h55, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,        9, 0, 0, 0, 0, 32'hA5A5A5A5, 1, 32'h0, 0, 1};
        vecs[8]  = '{0, 0, 32'h0,        9, 0, 1, 2, 0, 32'hA5A5A5A5, 1, 32'h0, 0, 1};
        vecs[9]  = '{0, 0, 32'h0,        2, 0, 1, 6, 0, 32'h0, 1, 32'h0, 0, 2};
        vecs[10] = '{0, 0, 32'h0,        2, 4, 1, 4, 1, 32'h0, 1, 32'h0, 0, 3};
        vecs[11] = '{0, 0, 32'h0,        2, 4, 0, 0, 0, 32'h0, 0, 32'h0, 1, 1};

        // Reset with a write pending: reads must still return zero
        rst_n = 0;
        idle();
        we_s = 1; waddr_s = 5; wdata_s = 32'hFFFF_FFFF;
        raddr_a_s = 5; raddr_b_s = 31;
        model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            get_out(c, da, ba, db, bb, cnt);
            chk("reset rdata_a", c, da, 0);
            chk("reset rbusy_a", c, 32'(ba), 0);
            chk("reset rdata_b", c, db, 0);
            chk("reset busy_cnt", c, 32'(cnt), 0);
        end
        $display("reset: raddr 5/31 read while rst_n low");
        tick();
        tick();
        rst_n = 1;
        idle();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            we_s = vecs[i].we; waddr_s = vecs[i].waddr; wdata_s = vecs[i].wdata;
            raddr_a_s = vecs[i].raddr_a; raddr_b_s = vecs[i].raddr_b;
            rsv_en_s = vecs[i].rsv_en; rsv_addr_s = vecs[i].rsv_addr; flush_s = vecs[i].flush;
            #1;
            get_out(0, da, ba, db, bb, cnt);
            $display("vec %0d: we=%0d wa=%0d wd=%h ra=%0d rb=%0d rsv=%0d@%0d fl=%0d -> rda=%h rba=%0d rdb=%h rbb=%0d cnt=%0d",
                     i, we_s, waddr_s, wdata_s, raddr_a_s, raddr_b_s, rsv_en_s, rsv_addr_s, flush_s,
                     da, ba, db, bb, cnt);
            chk("vec rdata_a", 0, da, vecs[i].e_rda);
            chk("vec rbusy_a", 0, 32'(ba), 32'(vecs[i].e_rba));
            chk("vec rdata_b", 0, db, vecs[i].e_rdb);
            chk("vec rbusy_b", 0, 32'(bb), 32'(vecs[i].e_rbb));
            chk("vec busy_cnt", 0, 32'(cnt), 32'(vecs[i].e_cnt));
            model_check();
            tick();
        end

        // Fill regs 1..10, reserve 4 of them, then assert reset between edges
        for (int r = 1; r <= 10; r++) begin
            idle();
            we_s = 1; waddr_s = 5'(r); wdata_s = $urandom;
            raddr_a_s = 5'(r); raddr_b_s = 5'(r - 1);
            #1; model_check();
            $display("fill: reg %0d <= %h", r, wdata_s);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            rsv_en_s = 1; rsv_addr_s = 5'(2 + 2 * k);
            #1; model_check();
            $display("reserve: reg %0d", rsv_addr_s);
            tick();
        end
        idle();
        raddr_a_s = 3; raddr_b_s = 4;
        we_s = 1; waddr_s = 7; wdata_s = 32'h0BAD_F00D; rsv_en_s = 1; rsv_addr_s = 8; flush_s = 1;
        #1; model_check();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            get_out(c, da, ba, db, bb, cnt);
            chk("async rdata_a", c, da, 0);
            chk("async rbusy_b", c, 32'(bb), 0);
            chk("async rdata_b", c, db, 0);
            chk("async busy_cnt", c, 32'(cnt), 0);
        end
        $display("async reset: asserted between clock edges");
        tick();
        rst_n = 1;
        idle();
        raddr_a_s = 3; raddr_b_s = 4;
        #1; model_check();
        tick();

        // Randomized traffic, addresses biased low to provoke collisions
        for (int i = 0; i < 400; i++) begin
            we_s       = 1'($urandom_range(0, 1));
            waddr_s    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wdata_s    = $urandom;
            raddr_a_s  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr_b_s  = ($urandom_range(0, 3) == 0) ? waddr_s : 5'($urandom_range(0, 7));
            rsv_en_s   = ($urandom_range(0, 2) == 0);
            rsv_addr_s = ($urandom_range(0, 3) == 0) ? waddr_s : 5'($urandom_range(0, 7));
            flush_s    = ($urandom_range(0, 15) == 0);
            #1;
            $display("rand %0d: we=%0d wa=%0d ra=%0d rb=%0d rsv=%0d@%0d fl=%0d cnt0=%0d cnt1=%0d",
                     i, we_s, waddr_s, raddr_a_s, raddr_b_s, rsv_en_s, rsv_addr_s, flush_s,
                     if0.busy_cnt, if1.busy_cnt);
            model_check();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
